// File: rtl/axi_wr_arb_pkg.sv
// Shared types and widths for the AXI4 write-channel arbiter.
package axi_wr_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2,
        ST_B    = 2'd3
    } arb_state_e;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    localparam int LEN_W   = 8;
    localparam int SIZE_W  = 3;
    localparam int BURST_W = 2;
    localparam int RESP_W  = 2;

endpackage

// File: rtl/axi_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr+1 (mod N).
module axi_rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        // i runs 1..N so the last master checked is the previous owner itself
        for (int i = 1; i <= N; i++) begin
            if (!gnt_vld && req[IDX_W'((int'(ptr) + i) % N)]) begin
                gnt_vld      = 1'b1;
                gnt_idx      = IDX_W'((int'(ptr) + i) % N);
                gnt[gnt_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_full_wr_arbiter.sv
// Round-robin sharing of one AXI4 write slave between NUM_MASTERS masters.
// Optional burst-length checker enabled by AXI_WR_ARB_LEN_CHECK_EN.
module axi_full_wr_arbiter
    import axi_wr_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int AXI_ID_WIDTH   = 1,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 6
) (
    input  logic                                     S_AXI_ACLK,
    input  logic                                     S_AXI_ARESETN,
    input  logic [NUM_MASTERS*AXI_ID_WIDTH-1:0]      S_AXI_AWID,
    input  logic [NUM_MASTERS*AXI_ADDR_WIDTH-1:0]    S_AXI_AWADDR,
    input  logic [NUM_MASTERS*LEN_W-1:0]             S_AXI_AWLEN,
    input  logic [NUM_MASTERS*SIZE_W-1:0]            S_AXI_AWSIZE,
    input  logic [NUM_MASTERS*BURST_W-1:0]           S_AXI_AWBURST,
    input  logic [NUM_MASTERS-1:0]                   S_AXI_AWVALID,
    output logic [NUM_MASTERS-1:0]                   S_AXI_AWREADY,
    input  logic [NUM_MASTERS*AXI_DATA_WIDTH-1:0]    S_AXI_WDATA,
    input  logic [NUM_MASTERS*AXI_DATA_WIDTH/8-1:0]  S_AXI_WSTRB,
    input  logic [NUM_MASTERS-1:0]                   S_AXI_WLAST,
    input  logic [NUM_MASTERS-1:0]                   S_AXI_WVALID,
    output logic [NUM_MASTERS-1:0]                   S_AXI_WREADY,
    output logic [NUM_MASTERS*AXI_ID_WIDTH-1:0]      S_AXI_BID,
    output logic [NUM_MASTERS*RESP_W-1:0]            S_AXI_BRESP,
    output logic [NUM_MASTERS-1:0]                   S_AXI_BVALID,
    input  logic [NUM_MASTERS-1:0]                   S_AXI_BREADY,
    output logic [AXI_ID_WIDTH-1:0]                  M_AXI_AWID,
    output logic [AXI_ADDR_WIDTH-1:0]                M_AXI_AWADDR,
    output logic [LEN_W-1:0]                         M_AXI_AWLEN,
    output logic [SIZE_W-1:0]                        M_AXI_AWSIZE,
    output logic [BURST_W-1:0]                       M_AXI_AWBURST,
    output logic                                     M_AXI_AWVALID,
    input  logic                                     M_AXI_AWREADY,
    output logic [AXI_DATA_WIDTH-1:0]                M_AXI_WDATA,
    output logic [AXI_DATA_WIDTH/8-1:0]              M_AXI_WSTRB,
    output logic                                     M_AXI_WLAST,
    output logic                                     M_AXI_WVALID,
    input  logic                                     M_AXI_WREADY,
    input  logic [AXI_ID_WIDTH-1:0]                  M_AXI_BID,
    input  logic [RESP_W-1:0]                        M_AXI_BRESP,
    input  logic                                     M_AXI_BVALID,
    output logic                                     M_AXI_BREADY,
    output logic [NUM_MASTERS-1:0]                   grant,
    output logic                                     len_err
);

    localparam int IDX_W  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int STRB_W = AXI_DATA_WIDTH / 8;

    // Per-master views of the flat buses, master 0 in the LSBs
    logic [NUM_MASTERS-1:0][AXI_ID_WIDTH-1:0]   aw_id;
    logic [NUM_MASTERS-1:0][AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [NUM_MASTERS-1:0][LEN_W-1:0]          aw_len;
    logic [NUM_MASTERS-1:0][SIZE_W-1:0]         aw_size;
    logic [NUM_MASTERS-1:0][BURST_W-1:0]        aw_burst;
    logic [NUM_MASTERS-1:0][AXI_DATA_WIDTH-1:0] w_data;
    logic [NUM_MASTERS-1:0][STRB_W-1:0]         w_strb;
    logic [NUM_MASTERS-1:0][AXI_ID_WIDTH-1:0]   b_id;
    logic [NUM_MASTERS-1:0][RESP_W-1:0]         b_resp;

    assign aw_id       = S_AXI_AWID;
    assign aw_addr     = S_AXI_AWADDR;
    assign aw_len      = S_AXI_AWLEN;
    assign aw_size     = S_AXI_AWSIZE;
    assign aw_burst    = S_AXI_AWBURST;
    assign w_data      = S_AXI_WDATA;
    assign w_strb      = S_AXI_WSTRB;
    assign S_AXI_BID   = b_id;
    assign S_AXI_BRESP = b_resp;

    arb_state_e             state;
    logic [IDX_W-1:0]       ptr;
    logic [IDX_W-1:0]       gidx;
    logic [NUM_MASTERS-1:0] arb_gnt;
    logic [IDX_W-1:0]       arb_idx;
    logic                   arb_vld;
    logic                   w_hs;
    logic                   b_hs;

    axi_rr_arbiter #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_rr (
        .req     (S_AXI_AWVALID),
        .ptr     (ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    assign w_hs = (state == ST_W) && M_AXI_WVALID && M_AXI_WREADY;
    assign b_hs = (state == ST_B) && M_AXI_BVALID && M_AXI_BREADY;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state         <= ST_IDLE;
            grant         <= '0;
            gidx          <= '0;
            ptr           <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_AWID    <= '0;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWLEN   <= '0;
            M_AXI_AWSIZE  <= '0;
            M_AXI_AWBURST <= '0;
        end else begin
            case (state)
                ST_IDLE: if (arb_vld) begin
                    grant         <= arb_gnt;
                    gidx          <= arb_idx;
                    M_AXI_AWVALID <= 1'b1;
                    M_AXI_AWID    <= aw_id[arb_idx];
                    M_AXI_AWADDR  <= aw_addr[arb_idx];
                    M_AXI_AWLEN   <= aw_len[arb_idx];
                    M_AXI_AWSIZE  <= aw_size[arb_idx];
                    M_AXI_AWBURST <= aw_burst[arb_idx];
                    state         <= ST_AW;
                end
                ST_AW: if (M_AXI_AWREADY) begin
                    M_AXI_AWVALID <= 1'b0;
                    ptr           <= gidx;
                    state         <= ST_W;
                end
                ST_W: if (w_hs && M_AXI_WLAST) state <= ST_B;
                ST_B: if (b_hs) begin
                    grant <= '0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Only the owner is routed; everyone else sees idle handshakes and OKAY
    always_comb begin
        S_AXI_AWREADY = '0;
        S_AXI_WREADY  = '0;
        S_AXI_BVALID  = '0;
        b_id          = '0;
        for (int i = 0; i < NUM_MASTERS; i++) b_resp[i] = RESP_OKAY;
        M_AXI_WVALID  = 1'b0;
        M_AXI_WDATA   = '0;
        M_AXI_WSTRB   = '0;
        M_AXI_WLAST   = 1'b0;
        M_AXI_BREADY  = 1'b0;
        case (state)
            ST_AW: S_AXI_AWREADY[gidx] = M_AXI_AWREADY;
            ST_W: begin
                M_AXI_WVALID       = S_AXI_WVALID[gidx];
                M_AXI_WDATA        = w_data[gidx];
                M_AXI_WSTRB        = w_strb[gidx];
                M_AXI_WLAST        = S_AXI_WLAST[gidx];
                S_AXI_WREADY[gidx] = M_AXI_WREADY;
            end
            ST_B: begin
                M_AXI_BREADY       = S_AXI_BREADY[gidx];
                S_AXI_BVALID[gidx] = M_AXI_BVALID;
                b_id[gidx]         = M_AXI_BID;
                b_resp[gidx]       = M_AXI_BRESP;
            end
            default: ;
        endcase
    end

`ifdef AXI_WR_ARB_LEN_CHECK_EN
    logic [LEN_W-1:0] beat_cnt;
    logic             len_err_q;

    // Count is the pre-increment beat index; AWLEN is the index of the last beat
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            beat_cnt  <= '0;
            len_err_q <= 1'b0;
        end else if (state == ST_AW) begin
            beat_cnt <= '0;
        end else if (w_hs) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (( M_AXI_WLAST && (beat_cnt != M_AXI_AWLEN)) ||
                (!M_AXI_WLAST && (beat_cnt == M_AXI_AWLEN)))
                len_err_q <= 1'b1;
        end
    end

    assign len_err = len_err_q;
`else
    assign len_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_full_wr_arbiter.sv
// Directed bench for axi_full_wr_arbiter: two masters, downstream slave driven inline.
module tb_axi_full_wr_arbiter;

    localparam int N  = 2;
    localparam int IW = 1;
    localparam int DW = 32;
    localparam int AW = 6;
    localparam int SW = DW / 8;

`ifdef AXI_WR_ARB_LEN_CHECK_EN
    localparam logic LEN_CHK = 1'b1;
`else
    localparam logic LEN_CHK = 1'b0;
`endif

    logic             S_AXI_ACLK = 1'b0;
    logic             S_AXI_ARESETN;
    logic [N*IW-1:0]  S_AXI_AWID;
    logic [N*AW-1:0]  S_AXI_AWADDR;
    logic [N*8-1:0]   S_AXI_AWLEN;
    logic [N*3-1:0]   S_AXI_AWSIZE;
    logic [N*2-1:0]   S_AXI_AWBURST;
    logic [N-1:0]     S_AXI_AWVALID;
    logic [N-1:0]     S_AXI_AWREADY;
    logic [N*DW-1:0]  S_AXI_WDATA;
    logic [N*SW-1:0]  S_AXI_WSTRB;
    logic [N-1:0]     S_AXI_WLAST;
    logic [N-1:0]     S_AXI_WVALID;
    logic [N-1:0]     S_AXI_WREADY;
    logic [N*IW-1:0]  S_AXI_BID;
    logic [N*2-1:0]   S_AXI_BRESP;
    logic [N-1:0]     S_AXI_BVALID;
    logic [N-1:0]     S_AXI_BREADY;
    logic [IW-1:0]    M_AXI_AWID;
    logic [AW-1:0]    M_AXI_AWADDR;
    logic [7:0]       M_AXI_AWLEN;
    logic [2:0]       M_AXI_AWSIZE;
    logic [1:0]       M_AXI_AWBURST;
    logic             M_AXI_AWVALID;
    logic             M_AXI_AWREADY;
    logic [DW-1:0]    M_AXI_WDATA;
    logic [SW-1:0]    M_AXI_WSTRB;
    logic             M_AXI_WLAST;
    logic             M_AXI_WVALID;
    logic             M_AXI_WREADY;
    logic [IW-1:0]    M_AXI_BID;
    logic [1:0]       M_AXI_BRESP;
    logic             M_AXI_BVALID;
    logic             M_AXI_BREADY;
    logic [N-1:0]     grant;
    logic             len_err;

    axi_full_wr_arbiter #(
        .NUM_MASTERS    (N),
        .AXI_ID_WIDTH   (IW),
        .AXI_DATA_WIDTH (DW),
        .AXI_ADDR_WIDTH (AW)
    ) dut (
        .S_AXI_ACLK    (S_AXI_ACLK),
        .S_AXI_ARESETN (S_AXI_ARESETN),
        .S_AXI_AWID    (S_AXI_AWID),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWLEN   (S_AXI_AWLEN),
        .S_AXI_AWSIZE  (S_AXI_AWSIZE),
        .S_AXI_AWBURST (S_AXI_AWBURST),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WLAST   (S_AXI_WLAST),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BID     (S_AXI_BID),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .M_AXI_AWID    (M_AXI_AWID),
        .M_AXI_AWADDR  (M_AXI_AWADDR),
        .M_AXI_AWLEN   (M_AXI_AWLEN),
        .M_AXI_AWSIZE  (M_AXI_AWSIZE),
        .M_AXI_AWBURST (M_AXI_AWBURST),
        .M_AXI_AWVALID (M_AXI_AWVALID),
        .M_AXI_AWREADY (M_AXI_AWREADY),
        .M_AXI_WDATA   (M_AXI_WDATA),
        .M_AXI_WSTRB   (M_AXI_WSTRB),
        .M_AXI_WLAST   (M_AXI_WLAST),
        .M_AXI_WVALID  (M_AXI_WVALID),
        .M_AXI_WREADY  (M_AXI_WREADY),
        .M_AXI_BID     (M_AXI_BID),
        .M_AXI_BRESP   (M_AXI_BRESP),
        .M_AXI_BVALID  (M_AXI_BVALID),
        .M_AXI_BREADY  (M_AXI_BREADY),
        .grant         (grant),
        .len_err       (len_err)
    );

    always #5 S_AXI_ACLK = ~S_AXI_ACLK;

    int          n_chk = 0;
    int          n_pass = 0;
    int          mon_beats = 0;
    logic [DW-1:0] mon_xor = '0;

    // Downstream-side record of every accepted W beat
    always @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESETN && M_AXI_WVALID && M_AXI_WREADY) begin
            mon_beats <= mon_beats + 1;
            mon_xor   <= mon_xor ^ M_AXI_WDATA;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge S_AXI_ACLK);
        #1;
    endtask

    function automatic logic [AW-1:0] addr_of(input int m);
        return AW'(16 * (m + 1));
    endfunction

    function automatic logic [DW-1:0] wdat(input int m, input int b);
        return 32'hA000_0000 | DW'(m << 8) | DW'(b);
    endfunction

    task automatic drive_aw(input int m, input int len);
        S_AXI_AWID[m*IW +: IW]   = 1'b1;
        S_AXI_AWADDR[m*AW +: AW] = addr_of(m);
        S_AXI_AWLEN[m*8 +: 8]    = 8'(len);
        S_AXI_AWSIZE[m*3 +: 3]   = 3'd2;
        S_AXI_AWBURST[m*2 +: 2]  = 2'd1;
    endtask

    // One full write from master m; eg is the expected one-hot grant
    task automatic run_txn(input int m, input logic [N-1:0] eg, input int len,
                           input int last_beat, input bit tog, input int bstall,
                           input bit raise1, input bit hold);
        int k, b, cyc, beats0;
        logic [DW-1:0] xor0, xexp;
        logic [3:0]    rexp;
        drive_aw(m, len);
        S_AXI_AWVALID[m] = 1'b1;
        k = 0;
        while (grant == '0 && k < 10) begin tick; k++; end
        chk("grant", grant, eg);
        #1;
        chk("aw_valid", M_AXI_AWVALID, 1);
        chk("aw_addr", M_AXI_AWADDR, addr_of(m));
        chk("aw_len", M_AXI_AWLEN, len);
        chk("aw_id", M_AXI_AWID, 1);
        chk("s_awready", S_AXI_AWREADY, eg);
        tick;
        if (!hold) S_AXI_AWVALID[m] = 1'b0;
        beats0 = mon_beats;
        xor0   = mon_xor;
        xexp   = '0;
        b = 0; cyc = 0;
        while (b <= last_beat && cyc < 64) begin
            M_AXI_WREADY = tog ? cyc[0] : 1'b1;
            S_AXI_WVALID[m]          = 1'b1;
            S_AXI_WDATA[m*DW +: DW]  = wdat(m, b);
            S_AXI_WSTRB[m*SW +: SW]  = '1;
            S_AXI_WLAST[m]           = (b == last_beat);
            #1;
            chk("m_wvalid", M_AXI_WVALID, 1);
            chk("m_wdata", M_AXI_WDATA, wdat(m, b));
            chk("m_wlast", M_AXI_WLAST, (b == last_beat));
            chk("s_wready", S_AXI_WREADY, M_AXI_WREADY ? eg : '0);
            tick;
            if (M_AXI_WREADY) begin xexp ^= wdat(m, b); b++; end
            cyc++;
        end
        if (b <= last_beat) chk("w_timeout", b, last_beat + 1);
        S_AXI_WVALID[m] = 1'b0;
        S_AXI_WLAST[m]  = 1'b0;
        M_AXI_WREADY    = 1'b1;
        chk("w_beats", mon_beats - beats0, last_beat + 1);
        chk("w_xor", mon_xor ^ xor0, xexp);
        if (raise1) begin drive_aw(1, 1); S_AXI_AWVALID[1] = 1'b1; end
        M_AXI_BVALID = 1'b1;
        M_AXI_BID    = 1'b1;
        M_AXI_BRESP  = 2'b10;
        for (int s = 0; s < bstall; s++) begin
            #1;
            chk("b_stall_bvalid", S_AXI_BVALID, eg);
            chk("b_stall_bready", M_AXI_BREADY, 0);
            chk("b_stall_grant", grant, eg);
            tick;
        end
        S_AXI_BREADY[m] = 1'b1;
        #1;
        rexp = 4'b0010 << (2 * m);
        chk("s_bvalid", S_AXI_BVALID, eg);
        chk("s_bid", S_AXI_BID, eg);
        chk("s_bresp", S_AXI_BRESP, rexp);
        chk("m_bready", M_AXI_BREADY, 1);
        tick;
        M_AXI_BVALID    = 1'b0;
        S_AXI_BREADY[m] = 1'b0;
        #1;
        chk("idle_grant", grant, 0);
        chk("idle_awvalid", M_AXI_AWVALID, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        S_AXI_ARESETN = 1'b0;
        S_AXI_AWID = '0; S_AXI_AWADDR = '0; S_AXI_AWLEN = '0;
        S_AXI_AWSIZE = '0; S_AXI_AWBURST = '0; S_AXI_AWVALID = '0;
        S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WLAST = '0; S_AXI_WVALID = '0;
        S_AXI_BREADY = '0;
        M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b1;
        M_AXI_BID = '0; M_AXI_BRESP = '0; M_AXI_BVALID = 1'b0;
        repeat (3) tick;
        chk("rst_grant", grant, 0);
        chk("rst_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}, 0);
        chk("rst_sready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID}, 0);
        chk("rst_payload", {M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_WDATA}, 0);
        chk("rst_len_err", len_err, 0);
        S_AXI_ARESETN = 1'b1;
        tick;

        // basic 4-beat burst, then single requester re-granted with WREADY toggling
        run_txn(0, 2'b01, 3, 3, 1'b0, 0, 1'b0, 1'b0);
        run_txn(0, 2'b01, 7, 7, 1'b1, 0, 1'b0, 1'b0);
        // B stalled 3 cycles while master1 requests; it waits for the B handshake
        run_txn(0, 2'b01, 1, 1, 1'b0, 3, 1'b1, 1'b0);
        run_txn(1, 2'b10, 1, 1, 1'b0, 0, 1'b0, 1'b0);

        // fairness with both holding AWVALID; previous owner was master1
        drive_aw(0, 1); drive_aw(1, 1);
        S_AXI_AWVALID = 2'b11;
        run_txn(0, 2'b01, 1, 1, 1'b0, 0, 1'b0, 1'b1);
        run_txn(1, 2'b10, 1, 1, 1'b0, 0, 1'b0, 1'b1);
        run_txn(0, 2'b01, 1, 1, 1'b0, 0, 1'b0, 1'b1);
        run_txn(1, 2'b10, 1, 1, 1'b0, 0, 1'b0, 1'b1);
        S_AXI_AWVALID = 2'b00;
        chk("len_err_clean", len_err, 0);

        // reset in the middle of a W burst
        drive_aw(0, 3);
        S_AXI_AWVALID[0] = 1'b1;
        tick;
        chk("mid_grant", grant, 2'b01);
        tick;
        S_AXI_AWVALID[0] = 1'b0;
        S_AXI_WVALID[0] = 1'b1; S_AXI_WDATA[0 +: DW] = wdat(0, 0);
        tick;
        S_AXI_WDATA[0 +: DW] = wdat(0, 1);
        #1;
        chk("mid_wvalid", M_AXI_WVALID, 1);
        S_AXI_ARESETN = 1'b0;
        #1;
        chk("mid_rst_grant", grant, 0);
        chk("mid_rst_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}, 0);
        chk("mid_rst_sready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID}, 0);
        S_AXI_WVALID = '0;
        tick; tick;
        S_AXI_ARESETN = 1'b1;
        tick;
        run_txn(0, 2'b01, 0, 0, 1'b0, 0, 1'b0, 1'b0);

        // AWLEN=3 but WLAST on the third beat
        run_txn(1, 2'b10, 3, 2, 1'b0, 0, 1'b0, 1'b0);
        chk("len_err_set", len_err, LEN_CHK);
        run_txn(0, 2'b01, 0, 0, 1'b0, 0, 1'b0, 1'b0);
        chk("len_err_sticky", len_err, LEN_CHK);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
